// File: rtl/soc_pkg.sv
// Shared SoC types and constants used by the input-conditioning blocks.
package soc_pkg;

    // Debouncer qualification states.
    typedef enum logic {
        DB_IDLE  = 1'b0,
        DB_COUNT = 1'b1
    } db_state_t;

    // Default number of consecutive stable cycles before a new level is accepted.
    localparam int DB_DEFAULT_STABLE = 1000;

endpackage

// File: rtl/input_debouncer_chk.sv
// Elaboration-time legality check of the debouncer parameters.
module input_debouncer_chk #(
    parameter int CNT_WIDTH     = 16,
    parameter int STABLE_CYCLES = 1000
) ();

    localparam longint MAX_STABLE = (64'sd1 <<< CNT_WIDTH) - 64'sd1;

    // STABLE_CYCLES must lie in 1 .. 2**CNT_WIDTH-1 so the counter never wraps.
    generate
        if ((STABLE_CYCLES < 32'sd1) || (longint'(STABLE_CYCLES) > MAX_STABLE)) begin : g_bad_stable
            $error("input_debouncer: STABLE_CYCLES out of range for CNT_WIDTH");
        end
    endgenerate

endmodule

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit. Both stages reset to
// RESET_LEVEL so a quiet input produces no transient after reset.
module sync_2ff #(
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1_r;

    // Two-stage capture of the asynchronous input into the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r <= RESET_LEVEL;
            q    <= RESET_LEVEL;
        end else begin
            s1_r <= d;
            q    <= s1_r;
        end
    end

endmodule

// File: rtl/input_debouncer.sv
// Debounces one asynchronous input: synchronizes it, requires the new level
// to persist STABLE_CYCLES consecutive cycles, then updates db_out and emits
// a one-cycle rise/fall pulse. A bounce back to the current level restarts
// qualification from zero.
module input_debouncer
    import soc_pkg::*;
#(
    parameter int   CNT_WIDTH     = 16,
    parameter int   STABLE_CYCLES = DB_DEFAULT_STABLE,
    parameter logic RESET_LEVEL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic db_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic busy
);

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 32'sd1);

    logic                 sync_q_s;
    logic                 mismatch_s;
    logic                 accept_s;
    db_state_t            state_r;
    db_state_t            state_nxt_s;
    logic [CNT_WIDTH-1:0] cnt_r;
    logic [CNT_WIDTH-1:0] cnt_nxt_s;
    logic                 db_nxt_s;
    logic                 rise_nxt_s;
    logic                 fall_nxt_s;

    input_debouncer_chk #(
        .CNT_WIDTH     (CNT_WIDTH),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_chk ();

    sync_2ff #(
        .RESET_LEVEL (RESET_LEVEL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (raw_in),
        .q   (sync_q_s)
    );

    assign mismatch_s = (sync_q_s != db_out);
    assign accept_s   = mismatch_s && (cnt_r == CNT_LAST);

    // Next-state, counter and output decode; acceptance takes precedence over counting.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        db_nxt_s    = db_out;
        rise_nxt_s  = 1'b0;
        fall_nxt_s  = 1'b0;
        case (state_r)
            DB_IDLE: begin
                if (accept_s) begin
                    db_nxt_s    = sync_q_s;
                    rise_nxt_s  = sync_q_s;
                    fall_nxt_s  = ~sync_q_s;
                    cnt_nxt_s   = CNT_ZERO;
                    state_nxt_s = DB_IDLE;
                end else if (mismatch_s) begin
                    cnt_nxt_s   = CNT_ONE;
                    state_nxt_s = DB_COUNT;
                end else begin
                    cnt_nxt_s   = CNT_ZERO;
                    state_nxt_s = DB_IDLE;
                end
            end
            DB_COUNT: begin
                if (accept_s) begin
                    db_nxt_s    = sync_q_s;
                    rise_nxt_s  = sync_q_s;
                    fall_nxt_s  = ~sync_q_s;
                    cnt_nxt_s   = CNT_ZERO;
                    state_nxt_s = DB_IDLE;
                end else if (mismatch_s) begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                    state_nxt_s = DB_COUNT;
                end else begin
                    // Bounced back to the accepted level: abandon the candidate.
                    cnt_nxt_s   = CNT_ZERO;
                    state_nxt_s = DB_IDLE;
                end
            end
            default: begin
                cnt_nxt_s   = CNT_ZERO;
                state_nxt_s = DB_IDLE;
            end
        endcase
    end

    // State, counter and registered outputs; reset discards any pending change.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= DB_IDLE;
            cnt_r      <= CNT_ZERO;
            db_out     <= RESET_LEVEL;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            db_out     <= db_nxt_s;
            rise_pulse <= rise_nxt_s;
            fall_pulse <= fall_nxt_s;
            busy       <= (state_nxt_s == DB_COUNT);
        end
    end

endmodule

// File: tb/tb_input_debouncer.sv
// Directed and randomized bench for input_debouncer (STABLE_CYCLES=4 and 1).
module tb_input_debouncer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic raw_in = 1'b0;
    logic db_out, rise_pulse, fall_pulse, busy;
    logic db_out1, rise_pulse1, fall_pulse1, busy1;

    int total = 0;
    int bad = 0;

    // Reference model state, index 0: STABLE=4, index 1: STABLE=1.
    logic m_s1[2], m_sync[2], m_db[2], m_rise[2], m_fall[2], m_busy[2];
    int   m_run[2];

    always #5 clk = ~clk;

    input_debouncer #(.CNT_WIDTH(16), .STABLE_CYCLES(4), .RESET_LEVEL(1'b0)) dut (
        .clk(clk), .rst(rst), .raw_in(raw_in),
        .db_out(db_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .busy(busy));

    input_debouncer #(.CNT_WIDTH(4), .STABLE_CYCLES(1), .RESET_LEVEL(1'b0)) dut1 (
        .clk(clk), .rst(rst), .raw_in(raw_in),
        .db_out(db_out1), .rise_pulse(rise_pulse1), .fall_pulse(fall_pulse1), .busy(busy1));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_s1[i] = 1'b0; m_sync[i] = 1'b0; m_db[i] = 1'b0;
            m_rise[i] = 1'b0; m_fall[i] = 1'b0; m_busy[i] = 1'b0; m_run[i] = 0;
        end
    endtask

    // Advance model i by one clock edge with the raw level seen at that edge.
    task automatic model_step(input int i, input int stable, input logic raw);
        m_rise[i] = 1'b0;
        m_fall[i] = 1'b0;
        if (m_sync[i] != m_db[i]) begin
            m_run[i] = m_run[i] + 1;
            if (m_run[i] == stable) begin
                m_db[i] = m_sync[i];
                m_rise[i] = m_sync[i];
                m_fall[i] = ~m_sync[i];
                m_run[i] = 0;
            end
        end else begin
            m_run[i] = 0;
        end
        m_busy[i] = (m_run[i] != 0);
        m_sync[i] = m_s1[i];
        m_s1[i] = raw;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        raw_in = 1'b0;
        for (int k = 0; k < 13; k++) begin
            if (k == 3) rst = 1'b0;
            tick();
            total++;
            if ({db_out, rise_pulse, fall_pulse, busy} !== 4'b0000) begin
                $display("FAIL reset cyc=%0d got db/rise/fall/busy=%b expected 0000", k,
                         {db_out, rise_pulse, fall_pulse, busy});
                bad++;
            end
        end
    endtask

    task automatic test_glitch();
        logic [3:0] exp;
        raw_in = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            if (k == 4) raw_in = 1'b0;
            tick();
            exp = {3'b000, ((k >= 3) && (k <= 5)) ? 1'b1 : 1'b0};
            total++;
            if ({db_out, rise_pulse, fall_pulse, busy} !== exp) begin
                $display("FAIL glitch edge=%0d got db/rise/fall/busy=%b expected %b", k,
                         {db_out, rise_pulse, fall_pulse, busy}, exp);
                bad++;
            end
        end
    endtask

    task automatic test_clean_rise();
        logic [3:0] exp;
        raw_in = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            exp = {(k >= 6) ? 1'b1 : 1'b0, (k == 6) ? 1'b1 : 1'b0, 1'b0,
                   ((k >= 3) && (k <= 5)) ? 1'b1 : 1'b0};
            total++;
            if ({db_out, rise_pulse, fall_pulse, busy} !== exp) begin
                $display("FAIL clean_rise edge=%0d got db/rise/fall/busy=%b expected %b", k,
                         {db_out, rise_pulse, fall_pulse, busy}, exp);
                bad++;
            end
        end
    endtask

    task automatic test_bounce();
        int falls = 0;
        int rises = 0;
        int rise_at = -1;
        // Return to 0 first so the bounce sequence targets a rising edge.
        raw_in = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (fall_pulse === 1'b1) falls++;
        end
        total++;
        if ((db_out !== 1'b0) || (falls != 1)) begin
            $display("FAIL bounce_prep got db=%b falls=%0d expected db=0 falls=1", db_out, falls);
            bad++;
        end
        for (int k = 1; k <= 25; k++) begin
            raw_in = (k <= 12) ? (((k - 1) / 2) % 2 == 0) : 1'b1;
            tick();
            if (rise_pulse === 1'b1) begin
                rises++;
                rise_at = k;
            end
            if (fall_pulse === 1'b1) falls++;
            total++;
            if (db_out !== ((k >= 18) ? 1'b1 : 1'b0)) begin
                $display("FAIL bounce_db edge=%0d got %b expected %b", k, db_out, (k >= 18));
                bad++;
            end
        end
        total++;
        if ((rises != 1) || (rise_at != 18) || (falls != 1)) begin
            $display("FAIL bounce_pulse got rises=%0d at=%0d falls=%0d expected rises=1 at=18 falls=1",
                     rises, rise_at, falls);
            bad++;
        end
    endtask

    task automatic test_reset_mid_count();
        // Entry: db_out=1 after the bounce test.
        raw_in = 1'b0;
        for (int k = 1; k <= 3; k++) tick();
        total++;
        if ({db_out, busy} !== 2'b11) begin
            $display("FAIL midcnt_pre got db/busy=%b expected 11", {db_out, busy});
            bad++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({db_out, rise_pulse, fall_pulse, busy} !== 4'b0000) begin
            $display("FAIL midcnt_rst got db/rise/fall/busy=%b expected 0000",
                     {db_out, rise_pulse, fall_pulse, busy});
            bad++;
        end
        for (int k = 1; k <= 10; k++) begin
            tick();
            total++;
            if ({db_out, rise_pulse, fall_pulse, busy} !== 4'b0000) begin
                $display("FAIL midcnt_after cyc=%0d got db/rise/fall/busy=%b expected 0000", k,
                         {db_out, rise_pulse, fall_pulse, busy});
                bad++;
            end
        end
    endtask

    task automatic test_random();
        logic lvl = 1'b0;
        int   hold;
        rst = 1'b1;
        raw_in = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
        for (int seg = 0; seg < 100; seg++) begin
            lvl = ~lvl;
            hold = $urandom_range(10, 1);
            raw_in = lvl;
            for (int c = 0; c < hold; c++) begin
                tick();
                model_step(0, 4, raw_in);
                model_step(1, 1, raw_in);
                total++;
                if ({db_out, rise_pulse, fall_pulse, busy} !== {m_db[0], m_rise[0], m_fall[0], m_busy[0]}) begin
                    $display("FAIL random4 seg=%0d got db/rise/fall/busy=%b expected %b", seg,
                             {db_out, rise_pulse, fall_pulse, busy}, {m_db[0], m_rise[0], m_fall[0], m_busy[0]});
                    bad++;
                end
                total++;
                if ({db_out1, rise_pulse1, fall_pulse1, busy1} !== {m_db[1], m_rise[1], m_fall[1], m_busy[1]}) begin
                    $display("FAIL random1 seg=%0d got db/rise/fall/busy=%b expected %b", seg,
                             {db_out1, rise_pulse1, fall_pulse1, busy1}, {m_db[1], m_rise[1], m_fall[1], m_busy[1]});
                    bad++;
                end
            end
        end
    endtask

    task automatic test_latency_one();
        logic [3:0] exp;
        rst = 1'b1;
        raw_in = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        raw_in = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            exp = {(k >= 3) ? 1'b1 : 1'b0, (k == 3) ? 1'b1 : 1'b0, 2'b00};
            total++;
            if ({db_out1, rise_pulse1, fall_pulse1, busy1} !== exp) begin
                $display("FAIL latency1 edge=%0d got db/rise/fall/busy=%b expected %b", k,
                         {db_out1, rise_pulse1, fall_pulse1, busy1}, exp);
                bad++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_clean_rise();
        test_bounce();
        test_reset_mid_count();
        test_random();
        test_latency_one();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/input_debouncer.md
# input_debouncer

Conditions one asynchronous, bouncy single-bit input (push-button, switch, external strobe) into a clean, clock-synchronous level plus one-cycle edge pulses. It sits directly upstream of the `dff`/register stages in the SoC input path, so everything downstream sees only a debounced, metastability-filtered signal. The block combines a two-flop synchronizer, a stability counter and a two-state FSM.

## Interface
Parameters:
- `CNT_WIDTH`, default 16: width of the stability counter.
- `STABLE_CYCLES`, default 1000: consecutive cycles a new level must persist before it is accepted. Legal range is 1 to 2**CNT_WIDTH-1; elaboration-time assertion on violation.
- `RESET_LEVEL`, default 1'b0: level assumed for `raw_in` and driven on `db_out` during and after reset.

Ports:
- `clk`, in, 1: single clock; all logic on posedge.
- `rst`, in, 1: reset, synchronous, active-high.
- `raw_in`, in, 1: asynchronous raw input.
- `db_out`, out, 1: debounced level (registered).
- `rise_pulse`, out, 1: one-cycle pulse when `db_out` goes 0→1 (registered).
- `fall_pulse`, out, 1: one-cycle pulse when `db_out` goes 1→0 (registered).
- `busy`, out, 1: high while a candidate level change is being qualified (registered).

## Operation
- Synchronizer: two flops, `raw_in`→`s1`→`sync_q`. Both flops are reset to `RESET_LEVEL`.
- `mismatch` = `sync_q != db_out`.
- FSM states are `IDLE` and `COUNT`. The counter `cnt` is `CNT_WIDTH` bits.
  - IDLE, `!mismatch`: stay; `cnt`=0.
  - IDLE or COUNT, `mismatch` and `cnt == STABLE_CYCLES-1`: accept.
    - `db_out` ← `sync_q`.
    - Matching pulse ← 1.
    - `cnt` ← 0, next state IDLE.
  - IDLE, `mismatch`, not accepting: go to COUNT, `cnt` ← 1.
  - COUNT, `mismatch`, not accepting: `cnt` ← `cnt`+1.
  - COUNT, `!mismatch` (bounce back): go to IDLE, `cnt` ← 0, no pulse. Qualification restarts from zero on the next mismatch.
- `STABLE_CYCLES`=1: every mismatch is accepted on its first sampled edge; COUNT is never entered.
- `busy` = registered (next state == COUNT).
- Pulses default to 0 every cycle. `rise_pulse` and `fall_pulse` are never high together.
- The counter never exceeds `STABLE_CYCLES-1`, so no wrap-around is possible.
- Reset values: `db_out`=`RESET_LEVEL`, `rise_pulse`=0, `fall_pulse`=0, `busy`=0, `cnt`=0, state IDLE, `s1`=`sync_q`=`RESET_LEVEL`.
- Reset has priority over everything. Reset during COUNT discards the pending change and emits no pulse.
- No spurious pulse after reset release when `raw_in`==`RESET_LEVEL`.

## Timing
- Let `raw_in` change and then hold before posedge E1.
  - `sync_q` shows the new level after E2.
  - `db_out` and the pulse update after edge E(`STABLE_CYCLES`+2).
- Total latency is `STABLE_CYCLES`+2 clocks. Default (1000) gives 1002 cycles.
- Pulse width is exactly one clock, aligned with the `db_out` transition cycle.
- `busy` rises the cycle after the first mismatch edge. It falls in the cycle `db_out` updates, or the cycle after a bounce-back.
- Any `raw_in` pulse shorter than `STABLE_CYCLES` synchronized cycles produces no change on any output except `busy`.

## Structure
- Shared package `soc_pkg`:
  - `typedef enum logic {DB_IDLE, DB_COUNT} db_state_t`
  - `localparam int DB_DEFAULT_STABLE = 1000`
- One sub-module, `sync_2ff`: two-flop synchronizer with synchronous active-high reset to a parameter `RESET_LEVEL`. It is separate from `dff` because `dff` has no reset. It is reusable for other asynchronous inputs.
- Top level `input_debouncer` holds the FSM, counter and output registers.

## Test plan
Unless noted, the bench uses `STABLE_CYCLES`=4 and `RESET_LEVEL`=0.
- **Reset:** `rst`=1 for 3 cycles, `raw_in`=0 → `db_out`=0, both pulses 0, `busy`=0, held through 10 cycles after release.
- **Clean rise:** `raw_in` 0→1 before edge E1 and held → `db_out`=1 after E6; `rise_pulse`=1 for exactly that one cycle; `fall_pulse` never set.
- **Glitch rejection:** `raw_in`=1 for 3 cycles then 0 → `db_out` stays 0 and no pulses. `busy` goes high, then returns to 0 after the bounce-back.
- **Bounce then settle:** `raw_in` toggles every 2 cycles for 12 cycles, then holds 1 → exactly one `rise_pulse`, `STABLE_CYCLES`+2 = 6 cycles after the last transition.
- **Reset mid-count:** `db_out`=1, `raw_in`→0, assert `rst` for 1 cycle while `busy`=1.
  - Next cycle: `db_out`=0 (the reset value), no `fall_pulse`, `busy`=0.
  - With `raw_in` still 0: no further pulses.
- **Randomized:** 100 random `raw_in` hold lengths of 1–10 cycles, checked cycle-by-cycle against a reference model. Also run with `STABLE_CYCLES`=1, expecting latency 3.
